// File: rtl/io_device_ctrl.sv
// Board IO controller: synchronised and debounced switches/confirm button, CPU-mapped LED and
// seven-segment registers, and a multiplexed 8-digit display scanner.
module io_device_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_DIV        = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_wen,
  input  logic [1:0]  io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_ren,
  output logic [15:0] io_rdata,
  input  logic [15:0] sw_i,
  input  logic        btn_conf_i,
  output logic        conf_o,
  output logic [15:0] led_o,
  output logic [7:0]  seg_o,
  output logic [7:0]  an_o
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCAN_DIV - 1);

  logic [15:0]     r_sw_meta, r_sw_sync, r_sw_cand, r_sw_stable;
  logic [DB_W-1:0] r_sw_cnt, r_btn_cnt;
  logic            r_btn_meta, r_btn_sync, r_btn_cand, r_btn_stable, r_btn_armed;
  logic            r_conf;
  logic [15:0]     r_rdata, r_led;
  logic [31:0]     r_tube;
  logic [7:0]      r_mask, r_seg, r_an;
  logic [SC_W-1:0] r_scan_cnt;
  logic [2:0]      r_idx;

  logic            w_sw_accept, w_btn_accept, w_wrap;
  logic [2:0]      w_idx_nxt;
  logic [3:0]      w_nibble;
  logic [7:0]      w_seg_dec;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 8'hC0;  4'h1: hex_seg = 8'hF9;  4'h2: hex_seg = 8'hA4;  4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;  4'h5: hex_seg = 8'h92;  4'h6: hex_seg = 8'h82;  4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;  4'h9: hex_seg = 8'h90;  4'hA: hex_seg = 8'h88;  4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;  4'hD: hex_seg = 8'hA1;  4'hE: hex_seg = 8'h86;  default: hex_seg = 8'h8E;
    endcase
  endfunction

  // A candidate is accepted once it has been seen unchanged for DEBOUNCE_CYCLES+1 samples.
  assign w_sw_accept  = (r_sw_sync == r_sw_cand) && (r_sw_cnt == DB_MAX);
  assign w_btn_accept = (r_btn_sync == r_btn_cand) && (r_btn_cnt == DB_MAX);

  assign w_wrap    = (r_scan_cnt == SC_MAX);
  assign w_idx_nxt = w_wrap ? r_idx + 3'd1 : r_idx;
  assign w_nibble  = r_tube[{w_idx_nxt, 2'b00} +: 4];

  always_comb begin
    w_seg_dec = hex_seg(w_nibble);
    if (r_mask[w_idx_nxt]) w_seg_dec = 8'hFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta    <= '0;
      r_sw_sync    <= '0;
      r_sw_cand    <= '0;
      r_sw_cnt     <= '0;
      r_sw_stable  <= '0;
      r_btn_meta   <= 1'b0;
      r_btn_sync   <= 1'b0;
      r_btn_cand   <= 1'b0;
      r_btn_cnt    <= '0;
      r_btn_stable <= 1'b0;
      r_btn_armed  <= 1'b0;
      r_conf       <= 1'b0;
    end else begin
      r_sw_meta  <= sw_i;
      r_sw_sync  <= r_sw_meta;
      r_btn_meta <= btn_conf_i;
      r_btn_sync <= r_btn_meta;

      if (r_sw_sync != r_sw_cand) begin
        r_sw_cand <= r_sw_sync;
        r_sw_cnt  <= '0;
      end else if (r_sw_cnt != DB_MAX) begin
        r_sw_cnt <= r_sw_cnt + 1'b1;
      end
      if (w_sw_accept) r_sw_stable <= r_sw_cand;

      if (r_btn_sync != r_btn_cand) begin
        r_btn_cand <= r_btn_sync;
        r_btn_cnt  <= '0;
      end else if (r_btn_cnt != DB_MAX) begin
        r_btn_cnt <= r_btn_cnt + 1'b1;
      end
      if (w_btn_accept) r_btn_stable <= r_btn_cand;
      // Only a press that follows an accepted release counts; a button held through reset never fires.
      if (w_btn_accept && !r_btn_cand) r_btn_armed <= 1'b1;
      r_conf <= w_btn_accept && r_btn_cand && !r_btn_stable && r_btn_armed;
    end
  end

  // io_wen/io_ren are single-cycle strobes with no back-pressure: a strobe high at an edge is
  // always consumed at that edge, and both may be high together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_led   <= '0;
      r_tube  <= '0;
      r_mask  <= '0;
    end else begin
      if (io_ren) r_rdata <= r_sw_stable;
      if (io_wen) begin
        case (io_addr)
          2'd0:    r_led  <= io_wdata[15:0];
          2'd1:    r_tube <= io_wdata;
          2'd2:    r_mask <= io_wdata[7:0];
          default: ;
        endcase
      end
    end
  end

  // Display registers sample the pre-write tube/mask, so a coinciding write shows one cycle late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= 3'd0;
      r_an       <= 8'hFE;
      r_seg      <= 8'hC0;
    end else begin
      r_scan_cnt <= w_wrap ? '0 : r_scan_cnt + 1'b1;
      r_idx      <= w_idx_nxt;
      r_an       <= ~(8'd1 << w_idx_nxt);
      r_seg      <= w_seg_dec;
    end
  end

  assign io_rdata = r_rdata;
  assign conf_o   = r_conf;
  assign led_o    = r_led;
  assign seg_o    = r_seg;
  assign an_o     = r_an;

endmodule

// File: tb/tb_io_device_ctrl.sv
// Bench for io_device_ctrl: directed scenarios plus randomized traffic, all outputs compared every
// cycle against a window/queue based behavioural model.
module tb_io_device_ctrl;

  localparam int DB = 4;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_wen = 1'b0;
  logic [1:0]  io_addr = 2'd0;
  logic [31:0] io_wdata = 32'd0;
  logic        io_ren = 1'b0;
  logic [15:0] sw_i = 16'd0;
  logic        btn_conf_i = 1'b0;
  logic [15:0] io_rdata;
  logic        conf_o;
  logic [15:0] led_o;
  logic [7:0]  seg_o;
  logic [7:0]  an_o;

  io_device_ctrl #(.DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .io_wen(io_wen), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ren(io_ren), .io_rdata(io_rdata), .sw_i(sw_i), .btn_conf_i(btn_conf_i),
    .conf_o(conf_o), .led_o(led_o), .seg_o(seg_o), .an_o(an_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          m_n;
  logic [15:0] raw_sw_q[$];
  logic        raw_btn_q[$];
  logic [15:0] sw_win[$];
  logic        btn_win[$];
  logic [15:0] m_stable;
  logic        m_btn, m_seen0;
  logic [31:0] m_tube;
  logic [7:0]  m_mask;
  logic [15:0] e_rdata, e_led;
  logic [7:0]  e_seg, e_an;
  logic        e_conf;

  int n_checks = 0;
  int n_fail = 0;
  int conf_seen = 0;

  task automatic model_reset();
    m_n = 0;
    raw_sw_q = {16'd0, 16'd0};
    raw_btn_q = {1'b0, 1'b0};
    sw_win = {16'd0};
    btn_win = {1'b0};
    m_stable = '0; m_btn = 1'b0; m_seen0 = 1'b0;
    m_tube = '0; m_mask = '0;
    e_rdata = '0; e_led = '0; e_conf = 1'b0;
    e_an = 8'hFE; e_seg = 8'hC0;
  endtask

  task automatic model_step();
    logic [15:0] s;
    logic        b, eq;
    int          idx;
    logic [3:0]  nib;
    m_n++;
    e_conf = 1'b0;
    if (io_ren) e_rdata = m_stable;
    raw_sw_q.push_back(sw_i);
    s = raw_sw_q.pop_front();
    sw_win.push_back(s);
    if (sw_win.size() > DB + 1) void'(sw_win.pop_front());
    eq = (sw_win.size() == DB + 1);
    foreach (sw_win[k]) if (sw_win[k] != s) eq = 1'b0;
    if (eq) m_stable = s;
    raw_btn_q.push_back(btn_conf_i);
    b = raw_btn_q.pop_front();
    btn_win.push_back(b);
    if (btn_win.size() > DB + 1) void'(btn_win.pop_front());
    eq = (btn_win.size() == DB + 1);
    foreach (btn_win[k]) if (btn_win[k] != b) eq = 1'b0;
    if (eq) begin
      if (b) begin
        e_conf = !m_btn && m_seen0;
        m_btn = 1'b1;
      end else begin
        m_seen0 = 1'b1;
        m_btn = 1'b0;
      end
    end
    idx = (m_n / SD) % 8;
    nib = 4'(m_tube >> (4 * idx));
    e_an = ~(8'd1 << idx);
    e_seg = m_mask[idx] ? 8'hFF : seg_tab[nib];
    if (io_wen) begin
      case (io_addr)
        2'd0: e_led = io_wdata[15:0];
        2'd1: m_tube = io_wdata;
        2'd2: m_mask = io_wdata[7:0];
        default: ;
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("an_o", 32'(an_o), 32'(e_an));
    chk("seg_o", 32'(seg_o), 32'(e_seg));
    chk("led_o", 32'(led_o), 32'(e_led));
    chk("io_rdata", 32'(io_rdata), 32'(e_rdata));
    chk("conf_o", 32'(conf_o), 32'(e_conf));
    if (conf_o === 1'b1) conf_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic write(input logic [1:0] a, input logic [31:0] d);
    io_wen = 1'b1; io_addr = a; io_wdata = d;
    tick();
    io_wen = 1'b0;
  endtask

  // ---------------- driver ----------------
  logic [7:0] an_lit  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] seg_lit [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
  int c0;

  initial begin
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_an", 32'(an_o), 32'h000000FE);
    chk("reset_seg", 32'(seg_o), 32'h000000C0);
    chk("reset_rdata", 32'(io_rdata), 32'h0);

    // switch acceptance latency and read-at-update ordering
    sw_i = 16'hA5A5;
    io_ren = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 3) chk("rd_early", 32'(io_rdata), 32'h0);
      if (i == 7) chk("rd_at_update", 32'(io_rdata), 32'h0);
      if (i == 8) chk("rd_accepted", 32'(io_rdata), 32'h0000A5A5);
    end
    io_ren = 1'b0;
    sw_i = 16'h0F0F;
    repeat (3) tick();
    chk("rd_hold", 32'(io_rdata), 32'h0000A5A5);

    // glitching switches never accepted
    do_reset();
    for (int i = 0; i < 20; i++) begin
      sw_i = ((i / 2) % 2 == 0) ? 16'h1234 : 16'h0000;
      tick();
    end
    sw_i = 16'h0000;
    io_ren = 1'b1;
    tick();
    io_ren = 1'b0;
    chk("glitch_rd", 32'(io_rdata), 32'h0);

    // button held through reset, then two presses
    btn_conf_i = 1'b1;
    do_reset();
    c0 = conf_seen;
    repeat (15) tick();
    chk("conf_held_reset", 32'(conf_seen - c0), 32'h0);
    btn_conf_i = 1'b0; repeat (10) tick();
    btn_conf_i = 1'b1; repeat (12) tick();
    btn_conf_i = 1'b0; repeat (12) tick();
    btn_conf_i = 1'b1; repeat (12) tick();
    btn_conf_i = 1'b0; repeat (10) tick();
    chk("conf_two_pulses", 32'(conf_seen - c0), 32'h2);

    // display scan of 89ABCDEF
    do_reset();
    write(2'd1, 32'h89ABCDEF);
    repeat (15) tick();
    for (int d = 0; d <= 8; d++) begin
      chk("scan_an", 32'(an_o), 32'(an_lit[d % 8]));
      chk("scan_seg", 32'(seg_o), 32'(seg_lit[d % 8]));
      tick();
      tick();
    end

    // blank mask, LED write, reserved address
    write(2'd2, 32'h00000001);
    write(2'd0, 32'h0000BEEF);
    chk("led_beef", 32'(led_o), 32'h0000BEEF);
    write(2'd3, 32'hFFFFFFFF);
    tick();
    chk("addr3_led", 32'(led_o), 32'h0000BEEF);
    for (int i = 0; i < 16 && (m_n % 16) != 0; i++) tick();
    chk("blank_an", 32'(an_o), 32'h000000FE);
    chk("blank_seg", 32'(seg_o), 32'h000000FF);
    tick();
    tick();
    chk("addr3_tube", 32'(seg_o), 32'h00000086);

    // asynchronous reset mid-scan at digit 5
    sw_i = 16'h3C3C;
    repeat (10) tick();
    io_ren = 1'b1;
    tick();
    io_ren = 1'b0;
    chk("rd_3c3c", 32'(io_rdata), 32'h00003C3C);
    for (int i = 0; i < 16 && (m_n % 16) != 10; i++) tick();
    chk("pre_rst_an", 32'(an_o), 32'h000000DF);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_an", 32'(an_o), 32'h000000FE);
    chk("async_seg", 32'(seg_o), 32'h000000C0);
    chk("async_led", 32'(led_o), 32'h0);
    chk("async_rdata", 32'(io_rdata), 32'h0);
    tick();
    rst_n = 1'b1;

    // randomized traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) sw_i = 16'($urandom);
      if ($urandom_range(0, 9) == 0) btn_conf_i = ~btn_conf_i;
      io_wen   = ($urandom_range(0, 3) == 0);
      io_addr  = 2'($urandom_range(0, 3));
      io_wdata = $urandom;
      io_ren   = ($urandom_range(0, 2) == 0);
      if (i == 1500) begin
        rst_n = 1'b0;
        model_reset();
      end
      if (i == 1503) rst_n = 1'b1;
      tick();
    end
    io_wen = 1'b0;
    io_ren = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_device_ctrl.md
IO_DEVICE_CTRL -- requirements
Module: io_device_ctrl

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 20000, meaning consecutive stable cycles required to accept a switch/button change.
REQ-002 SHALL provide parameter SCAN_DIV, default 50000, meaning clk cycles each display digit stays enabled.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 io_wen  input  1  CPU IO write strobe, one cycle per write.
REQ-007 io_addr  input  2  IO register select: 0 LED, 1 tube data, 2 tube blank mask, 3 reserved.
REQ-008 io_wdata  input  32  CPU store data.
REQ-009 io_ren  input  1  CPU IO read strobe.
REQ-010 io_rdata  output  16  debounced switch value returned to CPU.
REQ-011 sw_i  input  16  raw board switches, asynchronous.
REQ-012 btn_conf_i  input  1  raw confirm button, asynchronous.
REQ-013 conf_o  output  1  one-cycle confirm pulse to CPU.
REQ-014 led_o  output  16  LED drive, active-high.
REQ-015 seg_o  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-016 an_o  output  8  digit enables, active-low, bit i = digit i.

Function
REQ-017 sw_i and btn_conf_i SHALL each pass a 2-flop synchronizer before any other use.
REQ-018 Switch debounce: synchronized value differing from candidate SHALL reload candidate and clear counter; equal value SHALL increment counter; when counter reaches DEBOUNCE_CYCLES-1, sw_stable SHALL take candidate next edge, counter saturates.
REQ-019 Raw change before acceptance SHALL restart the count; glitches shorter than DEBOUNCE_CYCLES SHALL never reach sw_stable.
REQ-020 Button SHALL use the same debounce; conf_o SHALL pulse high exactly one cycle on each debounced 0->1 transition, never while held.
REQ-021 io_ren high SHALL register sw_stable into io_rdata at that edge (latency 1); io_ren low SHALL hold io_rdata.
REQ-022 Read coinciding with a sw_stable update SHALL return the pre-update value.
REQ-023 io_wen with addr 0 SHALL load led_o <= io_wdata[15:0]; addr 1 SHALL load 32-bit tube register; addr 2 SHALL load blank mask <= io_wdata[7:0]; addr 3 SHALL be ignored.
REQ-024 Writes SHALL take effect on outputs the cycle after the write edge; io_wen and io_ren in one cycle SHALL both be honoured.
REQ-025 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap digit index SHALL advance 0..7 then wrap to 0.
REQ-026 an_o SHALL be registered ~(1<<index); exactly one bit low at all times.
REQ-027 seg_o SHALL be registered hex decode of tube nibble [4*index+3:4*index] (0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E), dp always 1.
REQ-028 Blank mask bit for current index set SHALL force seg_o = FF; an_o unchanged.
REQ-029 Tube write coinciding with digit advance SHALL show old data for that one cycle, new data thereafter; no scan restart on write.

Reset
REQ-030 rst_n low SHALL immediately clear: led_o 0, tube 0, mask 0, io_rdata 0, sw_stable 0, candidates 0, counters 0, index 0, conf_o 0; an_o = FE, seg_o = C0.
REQ-031 Reset mid-debounce or mid-scan SHALL discard progress; after release, behaviour restarts exactly as from power-up.
REQ-032 conf_o SHALL not pulse on reset release even if button held; button must be debounced as 1 after a debounced 0.

Verification
REQ-033 DEBOUNCE_CYCLES=4: sw_i 0000->A5A5 held 10 cycles, io_ren -> io_rdata A5A5 only after 2 sync + 4 stable cycles; earlier read returns 0000.
REQ-034 sw_i toggles 1234/0000 every 2 cycles for 20 cycles -> sw_stable remains 0000.
REQ-035 btn_conf_i high 12 cycles, low, high again -> exactly two single-cycle conf_o pulses.
REQ-036 SCAN_DIV=2, write addr1 data 89ABCDEF -> digit0 seg 8E, digit1 86, ..., digit7 80, an_o FE,FD,...,7F, wrap to FE.
REQ-037 Write addr2 mask 01 then addr0 data 0000BEEF -> digit0 seg FF, led_o BEEF next cycle; addr3 write changes nothing.
REQ-038 Assert rst_n low mid-scan at index 5 with led_o BEEF -> outputs instantly an_o FE, seg_o C0, led_o 0000, io_rdata 0000.
